// File: rtl/ps2_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_ctrl
// Purpose  : Sequencer and decoder around a PS/2 byte receiver.
//            - Synchronises the raw PS/2 clock/data lines and produces a
//              one-cycle bit strobe (en) plus the data bit for the receiver.
//            - Tracks frame position (start, 8 data, parity, stop) and runs a
//              watchdog that clears the receiver when a frame stalls.
//            - Folds received bytes (E0 extended / F0 break prefixes) into
//              key events presented on a single-entry valid/ready register.
// Ports    : clk          system clock
//            i_sclr_n     synchronous reset, active-low
//            i_ps2_clk    raw PS/2 clock line (asynchronous)
//            i_ps2_dat    raw PS/2 data line (asynchronous)
//            o_en         one-cycle bit strobe to receiver
//            o_dat        synchronised data bit, valid with o_en
//            o_recv_sclr  synchronous clear to receiver, active-high
//            i_byte_en    receiver byte-valid pulse
//            i_byte       receiver byte
//            o_key_valid  key event available
//            i_key_ready  consumer accepts event
//            o_key_code   scan code
//            o_key_ext    event was E0-prefixed
//            o_key_break  event was F0-prefixed (release)
//            o_timeout    one-cycle pulse on watchdog abort
//            o_overflow   sticky: an event was dropped
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int CNT_W          = 14
) (
    input  logic       clk,
    input  logic       i_sclr_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_en,
    output logic       o_dat,
    output logic       o_recv_sclr,
    input  logic       i_byte_en,
    input  logic [7:0] i_byte,
    output logic       o_key_valid,
    input  logic       i_key_ready,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_key_break,
    output logic       o_timeout,
    output logic       o_overflow
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic [1:0]             clk_hist;
    logic                   dat_hist;
    logic                   ps2_fall;

    // clk_hist delays the synchronised clock once more so the strobe lands
    // SYNC_STAGES+1 cycles after the sampling edge; dat_hist keeps the data
    // bit aligned with that same point.
    assign ps2_fall = clk_hist[1] & ~clk_hist[0];

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_hist <= 2'b11;
            dat_hist <= 1'b1;
            o_en     <= 1'b0;
            o_dat    <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
            clk_hist <= {clk_hist[0], clk_sync[SYNC_STAGES-1]};
            dat_hist <= dat_sync[SYNC_STAGES-1];
            o_en     <= ps2_fall;
            if (ps2_fall) begin
                o_dat <= dat_hist;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame tracking and watchdog
    // ------------------------------------------------------------------
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] wd_cnt;
    logic             abort;

    assign abort       = (bit_cnt != 4'd0) && (wd_cnt == WD_LAST);
    assign o_recv_sclr = ~i_sclr_n | abort;

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            bit_cnt   <= 4'd0;
            wd_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= abort;

            // Abort outranks a coincident strobe.
            if (abort) begin
                bit_cnt <= 4'd0;
            end else if (o_en) begin
                if (bit_cnt == 4'd0) begin
                    bit_cnt <= o_dat ? 4'd0 : 4'd1;
                end else if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end

            if (abort || o_en || (bit_cnt == 4'd0)) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decoder FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       is_prefix;
    logic       is_discard;
    logic       emit;
    logic       ev_ext;
    logic       ev_brk;

    assign is_prefix  = (i_byte == 8'hE0) || (i_byte == 8'hF0);
    assign is_discard = (i_byte == 8'hAA) || (i_byte == 8'hFA) ||
                        (i_byte == 8'hEE) || (i_byte == 8'hFE) ||
                        (i_byte == 8'h00) || (i_byte == 8'hFF);

    always_ff @(posedge clk) begin
        if (!i_sclr_n || abort) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_byte_en) begin
            if (i_byte == 8'hE0) begin
                state_nxt = (state == ST_BRK) ? ST_EXT_BRK : ST_EXT;
            end else if (i_byte == 8'hF0) begin
                if (state == ST_EXT || state == ST_EXT_BRK) begin
                    state_nxt = ST_EXT_BRK;
                end else begin
                    state_nxt = ST_BRK;
                end
            end else if (state == ST_IDLE && is_discard) begin
                state_nxt = ST_IDLE;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        emit   = i_byte_en && !abort && !is_prefix &&
                 !((state == ST_IDLE) && is_discard);
        ev_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
        ev_brk = (state == ST_BRK) || (state == ST_EXT_BRK);
    end

    // ------------------------------------------------------------------
    // Single-entry event register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            o_key_valid <= 1'b0;
            o_key_code  <= 8'h00;
            o_key_ext   <= 1'b0;
            o_key_break <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            if (emit && (!o_key_valid || i_key_ready)) begin
                o_key_valid <= 1'b1;
                o_key_code  <= i_byte;
                o_key_ext   <= ev_ext;
                o_key_break <= ev_brk;
            end else if (emit) begin
                // Entry still held by the consumer: the new event is lost.
                o_overflow <= 1'b1;
            end else if (o_key_valid && i_key_ready) begin
                o_key_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_ctrl
// Purpose  : Directed self-checking bench for ps2_rx_ctrl. Drives PS/2 frames
//            on the raw lines and receiver bytes on i_byte_en/i_byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_ctrl;

    logic       clk = 1'b0;
    logic       sclr_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       en, dat, recv_sclr;
    logic       byte_en = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic [7:0] key_code;
    logic       key_ext, key_break, timeout, overflow;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ps2_rx_ctrl #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(300),
        .CNT_W         (14)
    ) dut (
        .clk        (clk),
        .i_sclr_n   (sclr_n),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_dat  (ps2_dat),
        .o_en       (en),
        .o_dat      (dat),
        .o_recv_sclr(recv_sclr),
        .i_byte_en  (byte_en),
        .i_byte     (byte_in),
        .o_key_valid(key_valid),
        .i_key_ready(key_ready),
        .o_key_code (key_code),
        .o_key_ext  (key_ext),
        .o_key_break(key_break),
        .o_timeout  (timeout),
        .o_overflow (overflow)
    );

    // Monitor: counts strobes/aborts and records the cycle they occur in.
    int          cyc = 0;
    int          en_cnt = 0;
    int          last_en = 0;
    int          sclr_cnt = 0;
    int          sclr_cyc = 0;
    int          to_cnt = 0;
    int          to_cyc = 0;
    logic [10:0] cap = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (en) begin
            en_cnt  = en_cnt + 1;
            last_en = cyc;
            cap     = {dat, cap[10:1]};
        end
        if (recv_sclr && sclr_n) begin
            sclr_cnt = sclr_cnt + 1;
            sclr_cyc = cyc;
        end
        if (timeout) begin
            to_cnt = to_cnt + 1;
            to_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_ev(input string tag, input logic [7:0] code, input logic ext, input logic brk);
        check({tag, "_valid"}, 32'(key_valid), 32'd1);
        check({tag, "_event"}, {22'd0, key_code, key_ext, key_break}, {22'd0, code, ext, brk});
    endtask

    // One PS/2 bit: data set while clock high, 100-cycle period.
    // The raw fall is driven on a negedge; o_en must be high only on the
    // 4th following negedge (3 cycles after the sampling posedge).
    task automatic send_bit(input logic b);
        logic [4:0] pat;
        logic       dbit;
        pat  = '0;
        dbit = 1'bx;
        @(negedge clk) ps2_dat = b;
        repeat (24) @(negedge clk);
        ps2_clk = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pat[k] = en;
            if (en) dbit = dat;
        end
        check("en_timing", 32'(pat), 32'b01000);
        check("en_data", 32'(dbit), 32'(b));
        repeat (45) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b);
        int base;
        base = en_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b);
        send_bit(1'b1);
        check("frame_en_count", 32'(en_cnt - base), 32'd11);
        check("frame_bits", 32'(cap), {21'd0, 1'b1, ~^b, b, 1'b0});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_en = 1'b1;
        byte_in = b;
        @(negedge clk);
        byte_en = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (5) @(negedge clk);
        check("rst_recv_sclr", 32'(recv_sclr), 32'd1);
        check("rst_outputs",
              {19'd0, en, dat, key_valid, key_code, key_ext, key_break, timeout, overflow},
              {19'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        sclr_n = 1'b1;
        repeat (3) @(negedge clk);
        check("run_recv_sclr", 32'(recv_sclr), 32'd0);

        // Full 0x1C frame, then its byte
        send_frame(8'h1C);
        check("frame_no_timeout", 32'(to_cnt), 32'd0);
        send_byte(8'h1C);
        check_ev("ev_1c", 8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        check("ev_1c_consumed", 32'(key_valid), 32'd0);

        // Break and extended sequences
        send_byte(8'hF0);
        check("f0_no_event", 32'(key_valid), 32'd0);
        send_byte(8'h1C);
        check_ev("ev_brk_1c", 8'h1C, 1'b0, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        check("e0f0_no_event", 32'(key_valid), 32'd0);
        send_byte(8'h75);
        check_ev("ev_ext_brk_75", 8'h75, 1'b1, 1'b1);
        send_byte(8'hE0);
        send_byte(8'h74);
        check_ev("ev_ext_74", 8'h74, 1'b1, 1'b0);

        // Discarded bytes in IDLE; E1 is an ordinary code
        send_byte(8'hAA);
        check("aa_discard", 32'(key_valid), 32'd0);
        send_byte(8'hFA);
        check("fa_discard", 32'(key_valid), 32'd0);
        send_byte(8'hE1);
        check_ev("ev_e1", 8'hE1, 1'b0, 1'b0);

        // Back-pressure and overflow
        @(negedge clk) key_ready = 1'b0;
        send_byte(8'h1C);
        check_ev("bp_hold_1c", 8'h1C, 1'b0, 1'b0);
        check("bp_no_overflow", 32'(overflow), 32'd0);
        send_byte(8'h32);
        check_ev("bp_drop_32", 8'h1C, 1'b0, 1'b0);
        check("bp_overflow", 32'(overflow), 32'd1);
        @(negedge clk) key_ready = 1'b1;
        @(negedge clk) key_ready = 1'b0;
        check("bp_consumed", 32'(key_valid), 32'd0);
        send_byte(8'h55);
        check_ev("bp_load_55", 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        key_ready = 1'b1;
        byte_en   = 1'b1;
        byte_in   = 8'h2A;
        @(negedge clk);
        byte_en   = 1'b0;
        key_ready = 1'b0;
        check_ev("bp_swap_2a", 8'h2A, 1'b0, 1'b0);
        check("overflow_sticky", 32'(overflow), 32'd1);
        @(negedge clk) key_ready = 1'b1;
        @(negedge clk);
        check("bp_final_drain", 32'(key_valid), 32'd0);

        // Stalled frame: start bit plus three data bits
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (400) @(negedge clk);
        check("to_sclr_count", 32'(sclr_cnt), 32'd1);
        check("to_sclr_delay", 32'(sclr_cyc - last_en), 32'd300);
        check("to_pulse_count", 32'(to_cnt), 32'd1);
        check("to_pulse_cycle", 32'(to_cyc - sclr_cyc), 32'd1);
        send_frame(8'h1C);
        check("post_to_no_timeout", 32'(to_cnt), 32'd1);
        send_byte(8'h1C);
        check_ev("post_to_1c", 8'h1C, 1'b0, 1'b0);

        // Reset mid-frame after E0
        send_byte(8'hE0);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk) sclr_n = 1'b0;
        @(negedge clk);
        check("midrst_recv_sclr", 32'(recv_sclr), 32'd1);
        check("midrst_outputs",
              {19'd0, en, dat, key_valid, key_code, key_ext, key_break, timeout, overflow},
              {19'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        sclr_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h1C);
        send_byte(8'h1C);
        check_ev("post_rst_1c", 8'h1C, 1'b0, 1'b0);
        check("post_rst_no_timeout", 32'(to_cnt), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
- Sequencer and decoder around the PS/2 byte receiver (start, 8 data LSB-first, odd parity, stop).
- Synchronises the raw PS/2 clock/data lines and produces the receiver's bit-enable strobe and data bit.
- Guards frames with a watchdog that clears the receiver on a stalled frame.
- Assembles received bytes (E0 extended prefix, F0 break prefix) into key events on a valid/ready interface.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for i_ps2_clk and i_ps2_dat (≥2).
- TIMEOUT_CYCLES, 10000, clk cycles without a PS/2 falling edge before an in-progress frame is aborted.
- CNT_W, 14, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- i_sclr_n  in  1  synchronous reset, active-low.
- i_ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- i_ps2_dat  in  1  raw PS/2 data line (asynchronous).
- o_en  out  1  one-cycle bit strobe to receiver.
- o_dat  out  1  synchronised data bit to receiver, valid when o_en=1.
- o_recv_sclr  out  1  synchronous clear to receiver, active-high.
- i_byte_en  in  1  receiver byte-valid pulse.
- i_byte  in  8  receiver byte.
- o_key_valid  out  1  key event available.
- i_key_ready  in  1  consumer accepts event.
- o_key_code  out  8  scan code.
- o_key_ext  out  1  event was E0-prefixed.
- o_key_break  out  1  event was F0-prefixed (key release).
- o_timeout  out  1  one-cycle pulse on watchdog abort.
- o_overflow  out  1  sticky: an event was dropped.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (i_sclr_n).
- Reset (i_sclr_n=0 at a clk edge):
  - synchroniser flops, o_dat and edge-history flop ← 1;
  - o_en, o_timeout, o_key_valid, o_key_code, o_key_ext, o_key_break, o_overflow ← 0;
  - bit count, watchdog and decoder state ← 0 / IDLE.
- o_recv_sclr = ~i_sclr_n | abort (combinational), so the receiver is held clear throughout reset.
- Edge detect:
  - o_en registered; high for exactly one cycle, SYNC_STAGES+1 cycles after the first clk edge that samples i_ps2_clk=0 following a 1.
  - o_dat registered alongside o_en from the synchronised data.
  - No strobe on rising edges or while i_ps2_clk stays constant.
- Frame tracking: bit count 0..10, advanced on each o_en.
  - count=0: go to 1 only if o_dat=0 (start bit), else stay 0.
  - count 1..9: increment.
  - count=10: go to 0 (stop bit).
  - Parity-failed frames still run to 10→0.
- Watchdog:
  - Cleared on every o_en; increments while count≠0; held at 0 while count=0.
  - When it reaches TIMEOUT_CYCLES-1: abort is a one-cycle pulse driving o_timeout and o_recv_sclr; bit count ← 0; decoder ← IDLE.
  - If abort and o_en coincide, abort wins and the strobe is ignored by frame tracking.
- Decoder FSM, states IDLE, EXT, BRK, EXT_BRK, acting only on i_byte_en:
  - 0xE0 → EXT from any state, except BRK → EXT_BRK.
  - 0xF0 → BRK from IDLE; EXT_BRK from EXT or EXT_BRK.
  - In IDLE, 0xAA, 0xFA, 0xEE, 0xFE, 0x00 and 0xFF are discarded; state unchanged.
  - Any other byte emits an event {code=byte, ext=state∈{EXT,EXT_BRK}, break=state∈{BRK,EXT_BRK}} and returns to IDLE.
  - 0xE1 is an ordinary code.
- Event register (single entry):
  - Emit with o_key_valid=0: load the event, o_key_valid ← 1 next cycle.
  - o_key_valid & i_key_ready: consume the event; o_key_valid ← 0 unless an emit occurs in the same cycle, in which case the new event is loaded and o_key_valid stays 1.
  - Emit with o_key_valid & ~i_key_ready: new event dropped, stored event unchanged, o_overflow ← 1 until reset.
  - Outputs stay stable while valid & ~ready.

Test Plan:
- Frame 0x1C (parity 0, stop 1), PS/2 period 100 cycles, TIMEOUT_CYCLES=300, i_key_ready=1 → exactly 11 o_en pulses, each 3 cycles after a raw falling edge; after i_byte_en, one event code=1C ext=0 break=0; o_timeout never pulses.
- Byte sequences F0,1C then E0,F0,75 → events {1C,ext0,brk1} and {75,ext1,brk1}; E0,74 → {74,ext1,brk0}.
- i_key_ready=0; bytes 1C then 32 → o_key_valid=1 holds code 1C; 32 dropped; o_overflow=1. Raise ready one cycle → valid drops. Ready=1 with simultaneous new byte 2A → valid stays 1, code=2A.
- Start bit plus 3 data bits, then PS/2 clock stops → o_recv_sclr and o_timeout high for 1 cycle, 300 cycles after the last o_en; a subsequent 0x1C frame decodes correctly.
- i_sclr_n=0 mid-frame after E0 received → o_recv_sclr=1 during reset, all outputs at reset values. A following 1C frame emits ext=0.
- Byte 0xAA and 0xFA in IDLE → no o_key_valid.
